// File: rtl/dmem_arbiter.sv
// Shared data-memory port arbiter: the CPU MEM stage has priority, and a DMA
// requester gets a 2-cycle grant/ack slot after at most MAX_CPU_RUN CPU grants.
module dmem_arbiter #(
  parameter int MAX_CPU_RUN = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] MAX_RUN = 4'(MAX_CPU_RUN);

  typedef enum logic {ARB, DMA_ACK} state_t;

  state_t      state;
  logic [3:0]  run_cnt;
  logic [31:0] dma_rdata_q;
  logic        cpu_gnt, dma_gnt;

  // Grant decode; nothing is granted while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (resetn) begin
      if (state == DMA_ACK)
        cpu_gnt = cpu_req;
      else if (dma_req && (!cpu_req || run_cnt >= MAX_RUN))
        dma_gnt = 1'b1;
      else
        cpu_gnt = cpu_req;
    end
  end

  assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
  assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  assign mem_we    = dma_gnt ? dma_we    : (cpu_gnt & cpu_we);
  assign cpu_stall = cpu_req & dma_gnt;
  assign cpu_rdata = mem_rdata;

  // Read data arrives in the ack cycle itself, so bypass the holding register then.
  assign dma_rdata = dma_ack ? mem_rdata : dma_rdata_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ARB;
      run_cnt     <= '0;
      dma_ack     <= 1'b0;
      dma_rdata_q <= '0;
      stall_cnt   <= '0;
    end else begin
      state   <= dma_gnt ? DMA_ACK : ARB;
      dma_ack <= dma_gnt;
      if (dma_ack)
        dma_rdata_q <= mem_rdata;
      if (!dma_req || dma_gnt)
        run_cnt <= '0;
      else if (cpu_gnt && run_cnt < MAX_RUN)
        run_cnt <= run_cnt + 4'd1;
      if (cpu_stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + randomized bench for dmem_arbiter against a cycle-level reference
// model of the arbitration rules, with a 1-cycle-latency memory behind mem_*.
module tb_dmem_arbiter;

  localparam int MAX = 8;

  logic        clock = 1'b0;
  logic        resetn, cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_stall, dma_ack, mem_we;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [15:0] stall_cnt;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:255] = '{default: '0};

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [31:0] m_mem [0:255];
  logic        m_ack;
  int          m_streak;
  int          m_stall;
  logic [31:0] m_dma_data, m_rd;
  logic        e_cpu_gnt, e_dma_gnt, e_we, e_stall;
  logic [31:0] e_addr, e_wdata;

  dmem_arbiter #(.MAX_CPU_RUN(MAX)) dut (
    .clock(clock), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  // synchronous-read data memory
  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr[9:2]];
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict this cycle's grant from the rules and compare every output.
  task automatic check_cycle();
    #1;
    e_cpu_gnt = 1'b0;
    e_dma_gnt = 1'b0;
    if (resetn) begin
      if (m_ack) e_cpu_gnt = cpu_req;
      else if (dma_req && (!cpu_req || m_streak >= MAX)) e_dma_gnt = 1'b1;
      else e_cpu_gnt = cpu_req;
    end
    e_we    = e_dma_gnt ? dma_we : (e_cpu_gnt & cpu_we);
    e_addr  = e_dma_gnt ? dma_addr : cpu_addr;
    e_wdata = e_dma_gnt ? dma_wdata : cpu_wdata;
    e_stall = cpu_req & e_dma_gnt;
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("dma_ack", 32'(dma_ack), 32'(m_ack));
    chk("dma_rdata", dma_rdata, m_ack ? m_rd : m_dma_data);
    chk("cpu_rdata", cpu_rdata, m_rd);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic advance();
    logic [31:0] rd_old;
    @(posedge clock);
    rd_old = m_rd;
    m_rd = m_mem[e_addr[9:2]];
    if (e_we) m_mem[e_addr[9:2]] = e_wdata;
    if (!resetn) begin
      m_ack = 1'b0; m_streak = 0; m_dma_data = '0; m_stall = 0;
    end else begin
      if (m_ack) m_dma_data = rd_old;
      m_ack = e_dma_gnt;
      if (!dma_req || e_dma_gnt) m_streak = 0;
      else if (e_cpu_gnt && m_streak < MAX) m_streak++;
      if (e_stall && m_stall < 65535) m_stall++;
    end
    @(negedge clock);
  endtask

  task automatic tick();
    check_cycle();
    advance();
  endtask

  task automatic dma_start(input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    m_ack = 1'b0; m_streak = 0; m_stall = 0; m_dma_data = '0; m_rd = '0;
    e_addr = '0; e_we = 1'b0; e_wdata = '0;
    @(posedge clock);
    @(negedge clock);

    // reset holds off all grants even with both sides requesting
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1111;
    dma_start(1'b1, 32'h20, 32'h2222);
    for (int i = 0; i < 2; i++) begin
      check_cycle();
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      advance();
    end
    resetn = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    tick();

    // CPU only: never stalls, address follows
    cpu_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cpu_we = 1'($urandom); cpu_addr = {22'd0, 8'($urandom), 2'b00}; cpu_wdata = $urandom;
      check_cycle();
      chk("cpu_only_addr", mem_addr, cpu_addr);
      chk("cpu_only_stall", 32'(cpu_stall), 32'd0);
      advance();
    end
    chk("cpu_only_stall_cnt", 32'(stall_cnt), 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;

    // DMA write then DMA read of 0x40
    dma_start(1'b1, 32'h40, 32'h12345678);
    tick();
    dma_req = 1'b0;
    tick();
    dma_start(1'b0, 32'h40, 32'h0);
    check_cycle();
    chk("dma_rd_gnt_addr", mem_addr, 32'h40);
    advance();
    dma_req = 1'b0;
    check_cycle();
    chk("dma_rd_ack", 32'(dma_ack), 32'd1);
    chk("dma_rd_data", dma_rdata, 32'h12345678);
    advance();
    check_cycle();
    chk("dma_rd_hold", dma_rdata, 32'h12345678);
    advance();

    // fairness: CPU run of MAX then DMA
    resetn = 1'b0; tick(); resetn = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
    dma_start(1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) dma_req = 1'b0;
      check_cycle();
      chk("fair_stall", 32'(cpu_stall), 32'(i == 8));
      chk("fair_addr", mem_addr, (i == 8) ? 32'h40 : 32'h4);
      chk("fair_ack", 32'(dma_ack), 32'(i == 9));
      advance();
    end
    chk("fair_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("fair_rdata", dma_rdata, 32'h12345678);
    cpu_req = 1'b0;

    // DMA write then CPU read of the same word
    dma_start(1'b1, 32'h80, 32'hCAFEF00D);
    tick();
    dma_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    tick();
    cpu_req = 1'b0;
    check_cycle();
    chk("raw_cpu_rdata", cpu_rdata, 32'hCAFEF00D);
    advance();

    // reset landing in the ack cycle abandons it
    dma_start(1'b0, 32'h80, 32'h0);
    tick();
    dma_req = 1'b0; resetn = 1'b0;
    check_cycle();
    chk("rst_ack_before", 32'(dma_ack), 32'd1);
    advance();
    resetn = 1'b1;
    check_cycle();
    chk("rst_ack_after", 32'(dma_ack), 32'd0);
    chk("rst_ack_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_ack_rdata", dma_rdata, 32'd0);
    advance();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cpu_req = ($urandom % 4) != 0; cpu_we = 1'($urandom);
      cpu_addr = {26'd0, 4'($urandom), 2'b00}; cpu_wdata = $urandom;
      if (m_ack) dma_req = 1'b0;
      else if (!dma_req && ($urandom % 3) == 0)
        dma_start(1'($urandom), {26'd0, 4'($urandom), 2'b00}, $urandom);
      resetn = ($urandom % 64) != 0;
      tick();
    end

    // saturation: preload the counter near the top, then keep stalling
    resetn = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0;
    tick();
    force dut.stall_cnt = 16'hFFF0;
    @(posedge clock);
    @(negedge clock);
    release dut.stall_cnt;
    m_stall = 16'hFFF0;
    cpu_req = 1'b1; cpu_addr = 32'h8;
    dma_start(1'b0, 32'h80, 32'h0);
    for (int i = 0; i < 200; i++) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
